gan_frame_serializer: RTL and testbench
=======================================

Name: gan_frame_serializer

Overview:
- Downstream consumer of the GAN top level: takes the nine Q8.24 generator pixels (pixel_1x1..pixel_3x3) and out_discriminator.
- After a programmable settle delay, snapshots them once.
- Binarises the image and classifies it as circle, cross or unknown.
- Streams the nine raw pixels out serially over a valid/ready handshake for logging or display.

Parameters:
- WIDTH, 32, pixel/score word width (signed Q8.24).
- SETTLE_CYCLES, 2, cycles waited after start before the snapshot, covering the upstream pipeline latency; 0 is legal.
- THRESH, 32'h00800000, signed binarisation and discriminator threshold (0.5 in Q8.24).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to capture and stream a frame; sampled only in IDLE.
- pixel_1x1 .. pixel_3x3  in  WIDTH each (signed)  generator pixels, row-major.
- disc_in  in  WIDTH (signed)  discriminator score.
- out_ready  in  1  downstream ready.
- out_valid  out  1  out_data is valid.
- out_data  out  WIDTH  current pixel.
- out_idx  out  4  pixel index 0..8; row-major, 0 = 1x1, 8 = 3x3.
- out_last  out  1  high with idx 8.
- bin_image  out  9  bit i = (pixel i >= THRESH).
- pattern  out  2  00 unknown, 01 circle, 10 cross; 11 never driven.
- disc_real  out  1  disc_in >= THRESH at capture.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset: asynchronous on rst=1. All outputs are 0, state is IDLE, snapshot registers are 0, counters are 0.
- States: IDLE, SETTLE, CAPTURE, STREAM, DONE.
  - IDLE: start=1 goes to SETTLE with the counter loaded to SETTLE_CYCLES. If SETTLE_CYCLES=0, go directly to CAPTURE.
  - SETTLE: lasts exactly SETTLE_CYCLES cycles, then CAPTURE.
  - CAPTURE: one cycle. At its closing edge, register all nine pixels, disc_in, bin_image, pattern and disc_real. Go to STREAM with idx=0.
  - STREAM: out_valid=1, out_data=snapshot[idx], out_idx=idx, out_last=(idx==8).
    - A transfer occurs on out_valid & out_ready at a rising edge.
    - Each transfer increments idx.
    - The transfer at idx 8 goes to DONE.
    - out_data, out_idx and out_last are held stable while out_ready=0.
  - DONE: done=1 for one cycle, out_valid=0, then IDLE.
- Latency (default parameters, start sampled at edge 0): SETTLE occupies cycles 1-2, CAPTURE cycle 3, out_valid first high in cycle 4. With out_ready held 1, beats occur in cycles 4-12 and done is high in cycle 13. busy is high in cycles 1-13.
- start while busy: ignored, no queuing. start in the DONE cycle: also ignored.
- Input changes after the CAPTURE edge do not affect streamed data or the classification outputs.
- Comparison: signed, >=. Negative values are always 0. A value exactly equal to THRESH gives 1.
- pattern (encoded into the pattern output):
  - bin_image == 9'h1EF (ring, centre 0) gives circle, 01.
  - bin_image == 9'h155 (X) gives cross, 10.
  - Any other value gives unknown, 00.
- bin_image, pattern and disc_real hold from CAPTURE until the next CAPTURE or reset.
- rst asserted mid-frame (any state) aborts immediately to IDLE with all outputs 0. The partial frame is not resumed.

Decomposition:
- Shared package gan_pkg holds:
  - Q_ONE=32'h01000000, Q_ZERO, Q_HALF=32'h00800000.
  - CIRCLE_MASK=9'h1EF, CROSS_MASK=9'h155.
  - Pattern codes PAT_UNKNOWN/PAT_CIRCLE/PAT_CROSS.
  - State encoding.
- One combinational sub-module, gan_pattern_matcher: takes nine pixels plus THRESH and produces bin_image and pattern. It is reusable by other GAN-side monitors.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all outputs 0, busy=0. Deassert; no activity without start.
- Circle frame: ring pixels Q_ONE, centre Q_ZERO, disc_in=Q_ONE, start at edge 0, out_ready=1 ->
  - out_valid cycles 4-12 with idx 0..8, data matching the inputs, out_last only at idx 8;
  - bin_image=9'h1EF, pattern=01, disc_real=1;
  - done in cycle 13.
- Cross frame with backpressure: X pattern Q_ONE/Q_ZERO, disc_in=Q_ZERO, out_ready toggling 1,0,... ->
  - data, idx and last are stable during stalls; exactly 9 beats in order;
  - pattern=10, disc_real=0.
- Threshold edges: pixel values 32'h00800000 -> 1, 32'h007FFFFF -> 0, 32'hFF000000 -> 0, with the remainder mixed -> bin_image matches bit by bit, pattern=00.
- Isolation: second start while busy, and all pixel inputs changed to Q_ONE after CAPTURE -> start ignored, streamed data equal to the original snapshot, exactly one done pulse.
- Mid-stream reset: assert rst after the idx 4 beat -> outputs 0 immediately (asynchronous), IDLE. A new start after release streams a complete 9-beat frame from idx 0. Repeat with SETTLE_CYCLES=0 -> out_valid in cycle 2.

Source files
------------

// File: rtl/gan_pkg.sv
// Shared GAN-side constants, pattern codes and serializer state encoding.
// Values are Q8.24 fixed point.
package gan_pkg;

  localparam logic [31:0] Q_ONE  = 32'h01000000;
  localparam logic [31:0] Q_ZERO = 32'h00000000;
  localparam logic [31:0] Q_HALF = 32'h00800000;

  localparam logic [8:0] CIRCLE_MASK = 9'h1EF;
  localparam logic [8:0] CROSS_MASK  = 9'h155;

  typedef enum logic [1:0] {
    PAT_UNKNOWN = 2'b00,
    PAT_CIRCLE  = 2'b01,
    PAT_CROSS   = 2'b10
  } pattern_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Exact-match classification; anything but the two reference shapes is unknown.
  function automatic pattern_t classify(input logic [8:0] bin);
    pattern_t pat;
    case (bin)
      CIRCLE_MASK: pat = PAT_CIRCLE;
      CROSS_MASK:  pat = PAT_CROSS;
      default:     pat = PAT_UNKNOWN;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/gan_frame_serializer_if.sv
// Pixel stream handshake between the frame serializer and its consumer.
interface gan_frame_serializer_if #(
  parameter int WIDTH = 32
) ();
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_idx;
  logic             out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/gan_pattern_matcher.sv
// Combinational binariser and shape classifier for a 3x3 Q8.24 image.
module gan_pattern_matcher
  import gan_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [8:0][WIDTH-1:0] pixels,
  input  logic [WIDTH-1:0]      thresh,
  output logic [8:0]            bin_image,
  output pattern_t              pattern
);

  // Signed compare: negatives never set a bit, equality to thresh does.
  always_comb begin
    bin_image = 9'd0;
    for (int i = 0; i < 9; i++) begin
      bin_image[i] = ($signed(pixels[i]) >= $signed(thresh));
    end
    pattern = classify(bin_image);
  end

endmodule

// File: rtl/gan_frame_serializer.sv
// Snapshots the GAN generator image after a settle delay, classifies it and
// streams the nine raw pixels out over a valid/ready handshake.
module gan_frame_serializer
  import gan_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               SETTLE_CYCLES = 2,
  parameter logic [WIDTH-1:0] THRESH        = 32'h00800000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] pixel_1x1,
  input  logic signed [WIDTH-1:0] pixel_1x2,
  input  logic signed [WIDTH-1:0] pixel_1x3,
  input  logic signed [WIDTH-1:0] pixel_2x1,
  input  logic signed [WIDTH-1:0] pixel_2x2,
  input  logic signed [WIDTH-1:0] pixel_2x3,
  input  logic signed [WIDTH-1:0] pixel_3x1,
  input  logic signed [WIDTH-1:0] pixel_3x2,
  input  logic signed [WIDTH-1:0] pixel_3x3,
  input  logic signed [WIDTH-1:0] disc_in,
  gan_frame_serializer_if.master  out_if,
  output logic [8:0]              bin_image,
  output logic [1:0]              pattern,
  output logic                    disc_real,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic [8:0][WIDTH-1:0] snap;
  logic [8:0][WIDTH-1:0] live;
  logic [8:0]           match_bin;
  pattern_t             match_pat;
  logic                 xfer;

  assign live = {pixel_3x3, pixel_3x2, pixel_3x1,
                 pixel_2x3, pixel_2x2, pixel_2x1,
                 pixel_1x3, pixel_1x2, pixel_1x1};
  assign xfer = (state == ST_STREAM) && out_if.out_ready;

  gan_pattern_matcher #(.WIDTH(WIDTH)) u_matcher (
    .pixels    (live),
    .thresh    (THRESH),
    .bin_image (match_bin),
    .pattern   (match_pat)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
        else       state_nxt = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt == CW'(1)) state_nxt = ST_CAPTURE;
        else               state_nxt = ST_SETTLE;
      end
      ST_CAPTURE: state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (xfer && (idx == 4'd8)) state_nxt = ST_DONE;
        else                       state_nxt = ST_STREAM;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Settle counter, beat index and the frame snapshot taken on the CAPTURE edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= {CW{1'b0}};
      idx       <= 4'd0;
      snap      <= '0;
      bin_image <= 9'd0;
      pattern   <= 2'b00;
      disc_real <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start) cnt <= CW'(SETTLE_CYCLES);
      else if (state == ST_SETTLE)     cnt <= cnt - CW'(1);

      if (state == ST_CAPTURE)               idx <= 4'd0;
      else if (xfer && (idx == 4'd8))        idx <= 4'd0;
      else if (xfer)                         idx <= idx + 4'd1;

      if (state == ST_CAPTURE) begin
        snap      <= live;
        bin_image <= match_bin;
        pattern   <= match_pat;
        disc_real <= ($signed(disc_in) >= $signed(THRESH));
      end
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    out_if.out_valid = 1'b0;
    out_if.out_data  = {WIDTH{1'b0}};
    out_if.out_idx   = 4'd0;
    out_if.out_last  = 1'b0;
    busy             = (state != ST_IDLE);
    done             = (state == ST_DONE);
    if (state == ST_STREAM) begin
      out_if.out_valid = 1'b1;
      out_if.out_data  = snap[idx];
      out_if.out_idx   = idx;
      out_if.out_last  = (idx == 4'd8);
    end else begin
      out_if.out_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_gan_frame_serializer.sv
// Randomised self-checking bench: two serializers (settle 2 and settle 0) share
// stimulus and are compared against a frame-level reference model.
module tb_gan_frame_serializer;

  localparam logic [31:0] THR  = 32'h00800000;
  localparam logic [31:0] ONE  = 32'h01000000;
  localparam logic [31:0] ZERO = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rdy;
  logic [31:0] pix [9];
  logic [31:0] disc;

  logic [8:0] bin_a, bin_b;
  logic [1:0] pat_a, pat_b;
  logic       dr_a, dr_b, busy_a, busy_b, done_a, done_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gan_frame_serializer_if #(.WIDTH(32)) ifa ();
  gan_frame_serializer_if #(.WIDTH(32)) ifb ();
  assign ifa.out_ready = rdy;
  assign ifb.out_ready = rdy;

  gan_frame_serializer #(.WIDTH(32), .SETTLE_CYCLES(2), .THRESH(32'h00800000)) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .pixel_1x1(pix[0]), .pixel_1x2(pix[1]), .pixel_1x3(pix[2]),
    .pixel_2x1(pix[3]), .pixel_2x2(pix[4]), .pixel_2x3(pix[5]),
    .pixel_3x1(pix[6]), .pixel_3x2(pix[7]), .pixel_3x3(pix[8]),
    .disc_in(disc), .out_if(ifa),
    .bin_image(bin_a), .pattern(pat_a), .disc_real(dr_a), .busy(busy_a), .done(done_a)
  );

  gan_frame_serializer #(.WIDTH(32), .SETTLE_CYCLES(0), .THRESH(32'h00800000)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .pixel_1x1(pix[0]), .pixel_1x2(pix[1]), .pixel_1x3(pix[2]),
    .pixel_2x1(pix[3]), .pixel_2x2(pix[4]), .pixel_2x3(pix[5]),
    .pixel_3x1(pix[6]), .pixel_3x2(pix[7]), .pixel_3x3(pix[8]),
    .disc_in(disc), .out_if(ifb),
    .bin_image(bin_b), .pattern(pat_b), .disc_real(dr_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {valid,last,done,busy,disc_real,pattern,bin_image,idx,data}
  function automatic logic [63:0] outs(input int d);
    if (d == 0)
      return {12'd0, ifa.out_valid, ifa.out_last, done_a, busy_a, dr_a, pat_a, bin_a,
              ifa.out_idx, ifa.out_data};
    return {12'd0, ifb.out_valid, ifb.out_last, done_b, busy_b, dr_b, pat_b, bin_b,
            ifb.out_idx, ifb.out_data};
  endfunction

  function automatic logic [8:0] model_bin(input logic [31:0] p [9]);
    logic [8:0] b;
    for (int i = 0; i < 9; i++) b[i] = (int'(p[i]) >= int'(THR));
    return b;
  endfunction

  function automatic logic [1:0] model_pat(input logic [8:0] b);
    if (b == 9'h1EF) return 2'b01;
    if (b == 9'h155) return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_mask(input logic [8:0] m);
    for (int i = 0; i < 9; i++) pix[i] = m[i] ? ONE : ZERO;
  endtask

  task automatic rand_pixels();
    for (int i = 0; i < 9; i++) begin
      case ($urandom_range(0, 5))
        0: pix[i] = ONE;
        1: pix[i] = ZERO;
        2: pix[i] = THR;
        3: pix[i] = THR - 32'd1;
        4: pix[i] = 32'hFF000000;
        default: pix[i] = $urandom;
      endcase
    end
    disc = $urandom_range(0, 1) ? ONE : $urandom;
  endtask

  // One frame: start at edge 0, watch both DUTs cycle by cycle against the model.
  task automatic run_frame(input bit bp, input bit mutate, input int abort_idx);
    logic [31:0] snap [9];
    logic [8:0]  e_bin;
    logic [1:0]  e_pat;
    logic        e_dr;
    int settle [2];
    int nbeat [2], ndone [2], first_v [2], done_cyc [2], last_cyc [2];
    bit stalled [2];
    logic [63:0] prev [2];
    logic [63:0] o;
    bit fin, aborted;
    settle[0] = 2; settle[1] = 0;
    for (int i = 0; i < 9; i++) snap[i] = pix[i];
    e_bin = model_bin(snap);
    e_pat = model_pat(e_bin);
    e_dr  = (int'(disc) >= int'(THR));
    for (int d = 0; d < 2; d++) begin
      nbeat[d] = 0; ndone[d] = 0; first_v[d] = -1; done_cyc[d] = -1; last_cyc[d] = -1;
      stalled[d] = 1'b0; prev[d] = 64'd0;
    end
    fin = 1'b0; aborted = 1'b0;
    rdy = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc <= 120 && !fin; cyc++) begin
      @(negedge clk);
      if (mutate && cyc == 5) begin
        for (int i = 0; i < 9; i++) pix[i] = ONE;
        disc  = ONE;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int d = 0; d < 2; d++) begin
        o = outs(d);
        if (stalled[d]) begin
          check_eq($sformatf("stall_valid_d%0d", d), {63'd0, o[51]}, 64'd1);
          check_eq($sformatf("stall_hold_d%0d", d), {28'd0, o[50], o[35:0]},
                   {28'd0, prev[d][50], prev[d][35:0]});
        end
        if (!bp) begin
          check_eq($sformatf("valid_c%0d_d%0d", cyc, d), {63'd0, o[51]},
                   {63'd0, (cyc >= settle[d] + 2 && cyc <= settle[d] + 10)});
          check_eq($sformatf("busy_c%0d_d%0d", cyc, d), {63'd0, o[48]},
                   {63'd0, (cyc <= settle[d] + 11)});
        end
        if (o[51] && first_v[d] < 0) first_v[d] = cyc;
        if (o[49]) begin ndone[d]++; done_cyc[d] = cyc; end
        if (o[51] && rdy) begin
          if (nbeat[d] < 9) begin
            check_eq($sformatf("beat%0d_data_d%0d", nbeat[d], d), {32'd0, o[31:0]},
                     {32'd0, snap[nbeat[d]]});
            check_eq($sformatf("beat%0d_idx_d%0d", nbeat[d], d), {60'd0, o[35:32]},
                     64'(nbeat[d]));
            check_eq($sformatf("beat%0d_last_d%0d", nbeat[d], d), {63'd0, o[50]},
                     {63'd0, (nbeat[d] == 8)});
          end else begin
            check_eq($sformatf("extra_beat_d%0d", d), 64'(nbeat[d]), 64'd8);
          end
          if (d == 0 && abort_idx >= 0 && int'(o[35:32]) == abort_idx) aborted = 1'b1;
          nbeat[d]++;
          last_cyc[d] = cyc;
        end
        stalled[d] = o[51] && !rdy;
        prev[d]    = o;
      end
      if (aborted) begin
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check_eq("abort_zero_d0", outs(0), 64'd0);
        check_eq("abort_zero_d1", outs(1), 64'd0);
        @(negedge clk); rst = 1'b0;
        fin = 1'b1;
      end else if (ndone[0] > 0 && ndone[1] > 0 && cyc >= done_cyc[0] + 3) begin
        fin = 1'b1;
      end
    end
    if (!fin) check_eq("frame_timeout", 64'd0, 64'd1);
    if (!aborted) begin
      for (int d = 0; d < 2; d++) begin
        o = outs(d);
        check_eq($sformatf("nbeat_d%0d", d), 64'(nbeat[d]), 64'd9);
        check_eq($sformatf("ndone_d%0d", d), 64'(ndone[d]), 64'd1);
        check_eq($sformatf("first_valid_d%0d", d), 64'(first_v[d]), 64'(settle[d] + 2));
        check_eq($sformatf("done_cycle_d%0d", d), 64'(done_cyc[d]),
                 bp ? 64'(last_cyc[d] + 1) : 64'(settle[d] + 11));
        check_eq($sformatf("bin_d%0d", d), {55'd0, o[44:36]}, {55'd0, e_bin});
        check_eq($sformatf("pattern_d%0d", d), {62'd0, o[46:45]}, {62'd0, e_pat});
        check_eq($sformatf("disc_real_d%0d", d), {63'd0, o[47]}, {63'd0, e_dr});
        check_eq($sformatf("idle_busy_d%0d", d), {63'd0, o[48]}, 64'd0);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    rdy   = 1'b1;
    rand_pixels();
    repeat (2) begin
      @(posedge clk); #1 start = 1'($urandom_range(0, 1));
      rand_pixels();
    end
    @(negedge clk);
    check_eq("reset_zero_d0", outs(0), 64'd0);
    check_eq("reset_zero_d1", outs(1), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("no_start_idle_d0", outs(0), 64'd0);
    check_eq("no_start_idle_d1", outs(1), 64'd0);

    set_mask(9'h1EF); disc = ONE;
    run_frame(1'b0, 1'b0, -1);

    set_mask(9'h155); disc = ZERO;
    run_frame(1'b1, 1'b0, -1);

    pix[0] = 32'h00800000; pix[1] = 32'h007FFFFF; pix[2] = 32'hFF000000;
    pix[3] = ONE;          pix[4] = ZERO;         pix[5] = 32'h7FFFFFFF;
    pix[6] = 32'h80000000; pix[7] = 32'h00800000; pix[8] = 32'h00800001;
    disc = 32'h007FFFFF;
    run_frame(1'b0, 1'b0, -1);

    rand_pixels();
    run_frame(1'b0, 1'b1, -1);

    set_mask(9'h1EF); disc = ONE;
    run_frame(1'b0, 1'b0, 4);
    rand_pixels();
    run_frame(1'b0, 1'b0, -1);

    for (int n = 0; n < 5; n++) begin
      rand_pixels();
      run_frame(1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
